// File: rtl/mux_sel_scheduler_if.sv
// Bundle between the requesters and the mux select scheduler.
// The master side drives requests and enable; the slave side (the scheduler) drives selects and status.
interface mux_sel_scheduler_if;
    logic [3:0] req;
    logic       en;
    logic       s1;
    logic       s0;
    logic [3:0] gnt;
    logic       valid;
    logic       done;

    modport master (output req, output en, input s1, input s0, input gnt, input valid, input done);
    modport slave  (input req, input en, output s1, output s0, output gnt, output valid, output done);
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator for a 4:1 mux: one winner holds the path for DWELL cycles or until it
// releases its request. All outputs are registered.
module mux_sel_scheduler #(
    parameter int DWELL = 4,
    parameter int CW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_scheduler_if.slave   bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] LOAD = CW'(DWELL - 1);

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    gnt_q;
    logic          s1_q;
    logic          s0_q;
    logic          valid_q;
    logic          done_q;

    logic          winFound_d;
    logic [1:0]    winIdx_d;
    logic          arbitrate_d;

    // While granted, ptr_q is the owner; the search starts just after it, so the owner is tried last.
    always_comb begin
        winFound_d = 1'b0;
        winIdx_d   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!winFound_d && bus.req[ptr_q + 2'(k)]) begin
                winFound_d = 1'b1;
                winIdx_d   = ptr_q + 2'(k);
            end
        end
    end

    assign arbitrate_d = (state_q == IDLE) || (cnt_q == '0) || !bus.req[ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (arbitrate_d) begin
            if (bus.en && winFound_d) begin
                state_q      <= GRANT;
                ptr_q        <= winIdx_d;
                cnt_q        <= LOAD;
                gnt_q        <= 4'b0001 << winIdx_d;
                {s1_q, s0_q} <= winIdx_d;
                valid_q      <= 1'b1;
                done_q       <= (LOAD == '0);
            end else begin
                // Selects deliberately keep their last value; consumers qualify with valid.
                state_q <= IDLE;
                cnt_q   <= '0;
                gnt_q   <= 4'b0000;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end
        end else begin
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.s1    = s1_q;
    assign bus.s0    = s0_q;
    assign bus.valid = valid_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: hand-derived vector table and corner sequences on a DWELL=4 instance,
// plus random traffic on DWELL=4 and DWELL=1 instances checked against a cycle-level reference model.
module tb_mux_sel_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sel_scheduler_if bus4 ();
    mux_sel_scheduler_if bus1 ();

    mux_sel_scheduler #(.DWELL(4), .CW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mux_sel_scheduler #(.DWELL(1), .CW(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Model tracks the owner and how many cycles of its dwell are left including the current one.
    typedef struct {
        int owner;
        int left;
        int ptr;
        int sel;
        bit done;
    } model_t;

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] q;
        logic [7:0] exp;
    } vec_t;

    model_t m4;
    model_t m1;
    bit     modelOn = 1'b0;
    int     errors  = 0;
    int     checks  = 0;
    vec_t   tbl[$];

    function automatic model_t modelStep(model_t m, logic [3:0] req, logic en, logic r, int dwell);
        model_t n;
        bit     ends;
        int     c;
        n = m;
        if (r) begin
            n.owner = -1; n.left = 0; n.ptr = 3; n.sel = 0; n.done = 1'b0;
            return n;
        end
        ends = (m.owner < 0) ? 1'b1 : ((m.left == 1) || (req[m.owner] !== 1'b1));
        if (!ends) begin
            n.left = m.left - 1;
            n.done = (n.left == 1);
        end else begin
            n.done  = 1'b0;
            n.owner = -1;
            n.left  = 0;
            if (en) begin
                for (int i = 1; i <= 4; i++) begin
                    c = (m.ptr + i) % 4;
                    if (n.owner < 0 && req[c] === 1'b1) begin
                        n.owner = c; n.ptr = c; n.sel = c; n.left = dwell; n.done = (dwell == 1);
                    end
                end
            end
        end
        return n;
    endfunction

    // Packs {gnt, s1, s0, valid, done}.
    function automatic logic [7:0] expv(int ch, bit v, int sel, bit d);
        logic [3:0] g;
        g = v ? 4'(1 << ch) : 4'b0000;
        return {g, 2'(sel), v, d};
    endfunction

    function automatic logic [7:0] modelOut(model_t m);
        return expv(m.owner, (m.owner >= 0), m.sel, m.done);
    endfunction

    function automatic vec_t mkVec(logic r, logic e, logic [3:0] q, logic [7:0] exp);
        vec_t v;
        v.r = r; v.e = e; v.q = q; v.exp = exp;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got gnt/sel/valid/done=%b expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q);
        rst      = r;
        bus4.req = q; bus1.req = q;
        bus4.en  = e; bus1.en  = e;
        @(posedge clk);
        m4 = modelStep(m4, q, e, r, 4);
        m1 = modelStep(m1, q, e, r, 1);
        if (r) modelOn = 1'b1;
        #1;
        if (modelOn) begin
            checkOutput("model_dwell4", {bus4.gnt, bus4.s1, bus4.s0, bus4.valid, bus4.done}, modelOut(m4));
            checkOutput("model_dwell1", {bus1.gnt, bus1.s1, bus1.s0, bus1.valid, bus1.done}, modelOut(m1));
        end
    endtask

    task automatic stepCheck(input string name, input logic r, input logic e, input logic [3:0] q,
                             input logic [7:0] exp);
        applyStimulus(r, e, q);
        checkOutput(name, {bus4.gnt, bus4.s1, bus4.s0, bus4.valid, bus4.done}, exp);
    endtask

    initial begin
        logic [3:0] rq;
        logic       re;
        logic       rr;
        m4 = '{owner: -1, left: 0, ptr: 3, sel: 0, done: 1'b0};
        m1 = m4;
        rst = 1'b0; bus4.req = 4'b0; bus1.req = 4'b0; bus4.en = 1'b0; bus1.en = 1'b0;

        // Reset held with all requesting, then full contention 0,1,2,3,0, then a lone channel 0.
        tbl.push_back(mkVec(1'b1, 1'b1, 4'b1111, expv(0, 0, 0, 0)));
        tbl.push_back(mkVec(1'b1, 1'b1, 4'b1111, expv(0, 0, 0, 0)));
        for (int g = 0; g < 5; g++)
            for (int c = 0; c < 4; c++)
                tbl.push_back(mkVec(1'b0, 1'b1, 4'b1111, expv(g % 4, 1, g % 4, (c == 3))));
        for (int g = 0; g < 2; g++)
            for (int c = 0; c < 4; c++)
                tbl.push_back(mkVec(1'b0, 1'b1, 4'b0001, expv(0, 1, 0, (c == 3))));

        for (int i = 0; i < tbl.size(); i++)
            stepCheck($sformatf("table%0d", i), tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].exp);

        // Early release: channel 2 drops after two grant cycles, channel 3 takes over at once.
        stepCheck("early_g2_c1", 1'b0, 1'b1, 4'b1100, expv(2, 1, 2, 0));
        stepCheck("early_g2_c2", 1'b0, 1'b1, 4'b1100, expv(2, 1, 2, 0));
        stepCheck("early_to_g3", 1'b0, 1'b1, 4'b1000, expv(3, 1, 3, 0));

        // Enable drop one cycle into the channel 3 grant.
        stepCheck("endrop_c2",   1'b0, 1'b0, 4'b1000, expv(3, 1, 3, 0));
        stepCheck("endrop_c3",   1'b0, 1'b0, 4'b1000, expv(3, 1, 3, 0));
        stepCheck("endrop_done", 1'b0, 1'b0, 4'b1000, expv(3, 1, 3, 1));
        stepCheck("endrop_idle", 1'b0, 1'b0, 4'b1000, expv(0, 0, 3, 0));
        stepCheck("endrop_idl2", 1'b0, 1'b0, 4'b1000, expv(0, 0, 3, 0));
        stepCheck("enrise_gnt",  1'b0, 1'b1, 4'b1000, expv(3, 1, 3, 0));

        // Mid-dwell reset during channel 3, then channel 0 wins first.
        stepCheck("mid_g3",      1'b0, 1'b1, 4'b1111, expv(3, 1, 3, 0));
        stepCheck("mid_rst",     1'b1, 1'b1, 4'b1111, expv(0, 0, 0, 0));
        stepCheck("mid_after",   1'b0, 1'b1, 4'b1111, expv(0, 1, 0, 0));

        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 9) < 7);
            re = ($urandom_range(0, 9) != 0);
            rr = ($urandom_range(0, 199) == 0);
            applyStimulus(rr, re, rq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
